// File: rtl/mips_def_pkg.sv
// mips_def: shared memory op codes and reset constants for the MIPS core
package mips_def;
  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_t;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
endpackage

// File: rtl/mem_access_unit_load_ext.sv
// load_ext: aligns the read word by byte offset and sign/zero-extends it per load op
//   rdata: word from memory, off: byte offset, op: M-stage op, data: extended result (0 for non-loads)
module load_ext
  import mips_def::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  mem_op_t     op,
  output logic [31:0] data
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    data = op == OP_LW  ? sh :
           op == OP_LH  ? {{16{sh[15]}}, sh[15:0]} :
           op == OP_LHU ? {16'b0, sh[15:0]} :
           op == OP_LB  ? {{24{sh[7]}}, sh[7:0]} :
           op == OP_LBU ? {24'b0, sh[7:0]} : 32'b0;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M stage of the MIPS pipeline; E/M and M/W registers, data bus drive, load extend
//   E-side: e_valid/e_mem_op/e_addr/e_rt_data/e_rt_addr/e_pc captured every edge
//   W-side forwarding: w_fwd_we/w_fwd_addr/w_fwd_data patch the store source in M
//   Bus: m_data_addr/m_data_wdata/m_data_byteen out, m_data_rdata in, m_inst_addr, m_align_err
//   W outputs: w_load_en/w_load_data/w_inst_addr
module mem_access_unit
  import mips_def::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] PC_RESET = mips_def::PC_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [3:0]        e_mem_op,
  input  logic [DATA_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_rt_data,
  input  logic [4:0]        e_rt_addr,
  input  logic [DATA_W-1:0] e_pc,
  input  logic              w_fwd_we,
  input  logic [4:0]        w_fwd_addr,
  input  logic [DATA_W-1:0] w_fwd_data,
  output logic [DATA_W-1:0] m_data_addr,
  output logic [DATA_W-1:0] m_data_wdata,
  output logic [3:0]        m_data_byteen,
  input  logic [DATA_W-1:0] m_data_rdata,
  output logic [DATA_W-1:0] m_inst_addr,
  output logic              m_align_err,
  output logic              w_load_en,
  output logic [DATA_W-1:0] w_load_data,
  output logic [DATA_W-1:0] w_inst_addr
);
  mem_op_t           m_op;
  logic [DATA_W-1:0] m_rt_data, rt, ext;
  logic [4:0]        m_rt_addr;
  logic [1:0]        off;
  logic              is_load;
  always_ff @(posedge clk) begin
    if (reset) begin
      m_op        <= OP_NONE;
      m_data_addr <= '0;
      m_rt_data   <= '0;
      m_rt_addr   <= '0;
      m_inst_addr <= PC_RESET;
      w_load_en   <= 1'b0;
      w_load_data <= '0;
      w_inst_addr <= PC_RESET;
    end else begin
      m_op        <= (e_valid && e_mem_op <= 4'd8) ? mem_op_t'(e_mem_op) : OP_NONE;
      m_data_addr <= e_addr;
      m_rt_data   <= e_rt_data;
      m_rt_addr   <= e_rt_addr;
      m_inst_addr <= e_pc;
      w_load_en   <= is_load && !m_align_err;
      w_load_data <= (is_load && !m_align_err) ? ext : '0;
      w_inst_addr <= m_inst_addr;
    end
  end
  always_comb begin
    off = m_data_addr[1:0];
    rt = (w_fwd_we && w_fwd_addr != 5'd0 && w_fwd_addr == m_rt_addr) ? w_fwd_data : m_rt_data;
    is_load = m_op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    m_align_err = (m_op inside {OP_LW, OP_SW} && off != 2'd0) ||
                  (m_op inside {OP_LH, OP_LHU, OP_SH} && off[0]);
    m_data_byteen = m_align_err     ? 4'b0000 :
                    m_op == OP_SW   ? 4'b1111 :
                    m_op == OP_SH   ? (off[1] ? 4'b1100 : 4'b0011) :
                    m_op == OP_SB   ? 4'(4'b0001 << off) : 4'b0000;
    m_data_wdata = m_align_err   ? rt :
                   m_op == OP_SH ? {2{rt[15:0]}} :
                   m_op == OP_SB ? {4{rt[7:0]}} : rt;
  end
  load_ext u_load_ext (
    .rdata(m_data_rdata),
    .off  (off),
    .op   (m_op),
    .data (ext)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of the M-stage memory unit against a reference model
module tb_mem_access_unit;
  logic        clk = 0, reset = 0;
  logic        e_valid = 0;
  logic [3:0]  e_mem_op = 0;
  logic [31:0] e_addr = 0, e_rt_data = 0, e_pc = 0;
  logic [4:0]  e_rt_addr = 0;
  logic        w_fwd_we = 0;
  logic [4:0]  w_fwd_addr = 0;
  logic [31:0] w_fwd_data = 0;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata = 0, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic        m_align_err, w_load_en;
  logic [31:0] w_load_data, w_inst_addr;
  int tests = 0, fails = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_mem_op(e_mem_op), .e_addr(e_addr),
    .e_rt_data(e_rt_data), .e_rt_addr(e_rt_addr), .e_pc(e_pc), .w_fwd_we(w_fwd_we),
    .w_fwd_addr(w_fwd_addr), .w_fwd_data(w_fwd_data), .m_data_addr(m_data_addr),
    .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
    .m_inst_addr(m_inst_addr), .m_align_err(m_align_err), .w_load_en(w_load_en),
    .w_load_data(w_load_data), .w_inst_addr(w_inst_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic v, input int op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] ra, input logic [31:0] pc);
    e_valid = v; e_mem_op = 4'(op); e_addr = a; e_rt_data = d; e_rt_addr = ra; e_pc = pc;
  endtask

  // Reference model: access size in bytes, 0 for non-memory ops
  function automatic int sz(input int op);
    return (op == 1 || op == 6) ? 4 : (op == 2 || op == 3 || op == 7) ? 2 :
           (op == 4 || op == 5 || op == 8) ? 1 : 0;
  endfunction
  function automatic bit is_st(input int op);
    return op >= 6 && op <= 8;
  endfunction
  function automatic bit is_ld(input int op);
    return op >= 1 && op <= 5;
  endfunction
  function automatic bit mis(input int op, input logic [31:0] a);
    return sz(op) > 0 && (a % sz(op)) != 0;
  endfunction
  function automatic logic [3:0] m_be(input int op, input logic [31:0] a);
    int s = sz(op);
    if (!is_st(op) || mis(op, a)) return 4'b0;
    return 4'(((1 << s) - 1) << (a % 4));
  endfunction
  function automatic logic [31:0] m_wd(input int op, input logic [31:0] a, input logic [31:0] r);
    if (!is_st(op) || mis(op, a) || sz(op) == 4) return r;
    return sz(op) == 2 ? (r & 32'hFFFF) * 32'h0001_0001 : (r & 32'hFF) * 32'h0101_0101;
  endfunction
  function automatic logic [31:0] m_ld(input int op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int s = sz(op);
    if (!is_ld(op) || mis(op, a)) return 32'h0;
    v = rd >> (8 * (a % 4));
    mask = s == 4 ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * s)) - 1);
    v = v & mask;
    if ((op == 2 || op == 4) && v[8 * s - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1;
    set_e(1, 6, 32'h44, 32'h55, 5'd1, 32'h99);
    tick(); tick();
    tests++; if (m_data_byteen !== 4'b0) begin fails++; $display("FAIL reset_byteen got %b want 0000", m_data_byteen); end
    tests++; if (m_align_err !== 1'b0) begin fails++; $display("FAIL reset_align got %b want 0", m_align_err); end
    tests++; if (w_load_en !== 1'b0) begin fails++; $display("FAIL reset_load_en got %b want 0", w_load_en); end
    tests++; if (w_load_data !== 32'h0) begin fails++; $display("FAIL reset_load_data got %h want 0", w_load_data); end
    tests++; if (m_inst_addr !== 32'h3000) begin fails++; $display("FAIL reset_m_inst got %h want 00003000", m_inst_addr); end
    tests++; if (w_inst_addr !== 32'h3000) begin fails++; $display("FAIL reset_w_inst got %h want 00003000", w_inst_addr); end
    tests++; if (m_data_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", m_data_addr); end
    reset = 0;
    set_e(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_sw_lw();
    set_e(1, 6, 32'h10, 32'h1234_5678, 5'd3, 32'h100);
    tick();
    tests++; if (m_data_byteen !== 4'b1111) begin fails++; $display("FAIL sw_byteen got %b want 1111", m_data_byteen); end
    tests++; if (m_data_wdata !== 32'h1234_5678) begin fails++; $display("FAIL sw_wdata got %h want 12345678", m_data_wdata); end
    tests++; if (m_data_addr !== 32'h10) begin fails++; $display("FAIL sw_addr got %h want 10", m_data_addr); end
    tests++; if (m_inst_addr !== 32'h100) begin fails++; $display("FAIL sw_m_inst got %h want 100", m_inst_addr); end
    set_e(1, 1, 32'h10, 32'h0, 5'd0, 32'h104);
    tick();
    m_data_rdata = 32'h1234_5678;
    set_e(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (m_data_byteen !== 4'b0) begin fails++; $display("FAIL lw_no_write got %b want 0000", m_data_byteen); end
    tick();
    tests++; if (w_load_en !== 1'b1) begin fails++; $display("FAIL lw_en got %b want 1", w_load_en); end
    tests++; if (w_load_data !== 32'h1234_5678) begin fails++; $display("FAIL lw_data got %h want 12345678", w_load_data); end
    tests++; if (w_inst_addr !== 32'h104) begin fails++; $display("FAIL lw_w_inst got %h want 104", w_inst_addr); end
  endtask

  task automatic test_byte_lanes();
    set_e(1, 8, 32'h13, 32'h0000_00A5, 5'd2, 32'h200);
    tick();
    tests++; if (m_data_byteen !== 4'b1000) begin fails++; $display("FAIL sb_byteen got %b want 1000", m_data_byteen); end
    tests++; if (m_data_wdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_wdata got %h want a5a5a5a5", m_data_wdata); end
    set_e(1, 4, 32'h13, 0, 0, 32'h204);
    tick();
    m_data_rdata = 32'hA500_0000;
    set_e(1, 5, 32'h13, 0, 0, 32'h208);
    tick();
    tests++; if (w_load_data !== 32'hFFFF_FFA5) begin fails++; $display("FAIL lb_data got %h want ffffffa5", w_load_data); end
    set_e(0, 0, 0, 0, 0, 0);
    tick();
    tests++; if (w_load_data !== 32'h0000_00A5) begin fails++; $display("FAIL lbu_data got %h want 000000a5", w_load_data); end
  endtask

  task automatic test_halfwords();
    m_data_rdata = 32'h8001_7FFF;
    set_e(1, 2, 32'h2, 0, 0, 32'h300);
    tick();
    set_e(1, 3, 32'h2, 0, 0, 32'h304);
    tick();
    tests++; if (w_load_data !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_data got %h want ffff8001", w_load_data); end
    set_e(1, 7, 32'h2, 32'hCAFE_1234, 5'd4, 32'h308);
    tick();
    tests++; if (w_load_data !== 32'h0000_8001) begin fails++; $display("FAIL lhu_data got %h want 00008001", w_load_data); end
    tests++; if (m_data_byteen !== 4'b1100) begin fails++; $display("FAIL sh_byteen got %b want 1100", m_data_byteen); end
    tests++; if (m_data_wdata !== 32'h1234_1234) begin fails++; $display("FAIL sh_wdata got %h want 12341234", m_data_wdata); end
    set_e(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_misalign();
    set_e(1, 6, 32'h5, 32'h1111_2222, 5'd1, 32'h400);
    tick();
    tests++; if (m_data_byteen !== 4'b0) begin fails++; $display("FAIL sw_mis_byteen got %b want 0000", m_data_byteen); end
    tests++; if (m_align_err !== 1'b1) begin fails++; $display("FAIL sw_mis_err got %b want 1", m_align_err); end
    set_e(1, 2, 32'h3, 0, 0, 32'h404);
    tick();
    m_data_rdata = 32'hFFFF_FFFF;
    set_e(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (m_align_err !== 1'b1) begin fails++; $display("FAIL lh_mis_err got %b want 1", m_align_err); end
    tick();
    tests++; if (w_load_en !== 1'b0) begin fails++; $display("FAIL lh_mis_en got %b want 0", w_load_en); end
    tests++; if (w_load_data !== 32'h0) begin fails++; $display("FAIL lh_mis_data got %h want 0", w_load_data); end
  endtask

  task automatic test_forwarding();
    set_e(1, 6, 32'h20, 32'h0, 5'd8, 32'h500);
    tick();
    set_e(0, 0, 0, 0, 0, 0);
    w_fwd_we = 1; w_fwd_addr = 5'd8; w_fwd_data = 32'hDEAD_BEEF;
    #1;
    tests++; if (m_data_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL fwd_hit got %h want deadbeef", m_data_wdata); end
    w_fwd_addr = 5'd0;
    #1;
    tests++; if (m_data_wdata !== 32'h0) begin fails++; $display("FAIL fwd_r0 got %h want 0", m_data_wdata); end
    w_fwd_addr = 5'd8; w_fwd_we = 0;
    #1;
    tests++; if (m_data_wdata !== 32'h0) begin fails++; $display("FAIL fwd_we_off got %h want 0", m_data_wdata); end
    w_fwd_addr = 5'd0; w_fwd_data = 0;
  endtask

  task automatic test_reset_mid();
    set_e(1, 6, 32'h30, 32'h1, 5'd1, 32'h600);
    tick();
    tests++; if (m_data_byteen !== 4'b1111) begin fails++; $display("FAIL pre_reset_byteen got %b want 1111", m_data_byteen); end
    reset = 1;
    tick();
    tests++; if (m_data_byteen !== 4'b0) begin fails++; $display("FAIL mid_reset_byteen got %b want 0000", m_data_byteen); end
    tests++; if (m_inst_addr !== 32'h3000) begin fails++; $display("FAIL mid_reset_inst got %h want 00003000", m_inst_addr); end
    reset = 0;
    set_e(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_bubble();
    set_e(0, 6, 32'h40, 32'h7, 5'd1, 32'h700);
    tick();
    tests++; if (m_data_byteen !== 4'b0) begin fails++; $display("FAIL bubble_byteen got %b want 0000", m_data_byteen); end
    set_e(1, 12, 32'h41, 32'h7, 5'd1, 32'h704);
    tick();
    tests++; if (m_data_byteen !== 4'b0) begin fails++; $display("FAIL badop_byteen got %b want 0000", m_data_byteen); end
    tests++; if (m_align_err !== 1'b0) begin fails++; $display("FAIL badop_err got %b want 0", m_align_err); end
    set_e(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    localparam int N = 300;
    int op[N], eop[N];
    logic v[N], fwe[N];
    logic [31:0] ad[N], rtd[N], pc[N], rd[N], fda[N], r;
    logic [4:0] rta[N], fad[N];
    for (int k = 0; k < N; k++) begin
      v[k] = $urandom_range(0, 7) != 0;
      op[k] = $urandom_range(0, 10);
      eop[k] = (v[k] && op[k] <= 8) ? op[k] : 0;
      ad[k] = $urandom & 32'hFFFF_FFFF;
      rtd[k] = $urandom;
      rta[k] = 5'($urandom_range(0, 3));
      pc[k] = $urandom;
      rd[k] = $urandom;
      fwe[k] = $urandom_range(0, 1);
      fad[k] = 5'($urandom_range(0, 3));
      fda[k] = $urandom;
    end
    for (int i = 0; i <= N + 1; i++) begin
      if (i >= 1 && i <= N) begin
        m_data_rdata = rd[i-1]; w_fwd_we = fwe[i-1]; w_fwd_addr = fad[i-1]; w_fwd_data = fda[i-1];
      end else begin
        w_fwd_we = 0; w_fwd_addr = 0; w_fwd_data = 0;
      end
      if (i < N) set_e(v[i], op[i], ad[i], rtd[i], rta[i], pc[i]);
      else set_e(0, 0, 0, 0, 0, 0);
      #1;
      if (i >= 1 && i <= N) begin
        int j = i - 1;
        r = (fwe[j] && fad[j] != 0 && fad[j] == rta[j]) ? fda[j] : rtd[j];
        tests++; if (m_data_byteen !== m_be(eop[j], ad[j])) begin fails++; $display("FAIL rnd_byteen[%0d] op %0d addr %h got %b want %b", j, eop[j], ad[j], m_data_byteen, m_be(eop[j], ad[j])); end
        tests++; if (m_data_wdata !== m_wd(eop[j], ad[j], r)) begin fails++; $display("FAIL rnd_wdata[%0d] op %0d got %h want %h", j, eop[j], m_data_wdata, m_wd(eop[j], ad[j], r)); end
        tests++; if (m_align_err !== mis(eop[j], ad[j])) begin fails++; $display("FAIL rnd_err[%0d] op %0d addr %h got %b want %b", j, eop[j], ad[j], m_align_err, mis(eop[j], ad[j])); end
        tests++; if (m_data_addr !== ad[j] || m_inst_addr !== pc[j]) begin fails++; $display("FAIL rnd_maddr[%0d] got %h/%h want %h/%h", j, m_data_addr, m_inst_addr, ad[j], pc[j]); end
      end
      if (i >= 2) begin
        int j = i - 2;
        tests++; if (w_load_en !== (is_ld(eop[j]) && !mis(eop[j], ad[j]))) begin fails++; $display("FAIL rnd_load_en[%0d] op %0d got %b want %b", j, eop[j], w_load_en, is_ld(eop[j]) && !mis(eop[j], ad[j])); end
        tests++; if (w_load_data !== m_ld(eop[j], ad[j], rd[j])) begin fails++; $display("FAIL rnd_load_data[%0d] op %0d addr %h got %h want %h", j, eop[j], ad[j], w_load_data, m_ld(eop[j], ad[j], rd[j])); end
        tests++; if (w_inst_addr !== pc[j]) begin fails++; $display("FAIL rnd_w_inst[%0d] got %h want %h", j, w_inst_addr, pc[j]); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_sw_lw();
    test_byte_lanes();
    test_halfwords();
    test_misalign();
    test_forwarding();
    test_reset_mid();
    test_bubble();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
